ram_dp_pipe: RTL and testbench

Parametrised single-clock, true dual-port RAM with byte-lane write enables, configurable width, depth and read-during-write mode, plus an optional output pipeline stage. Ports carry a registered read-valid strobe and a write-collision flag, and a clear engine zero-fills the array after reset or on command. It replaces the fixed 32-bit, four-lane dual-port RAM used for CPU instruction/data memory, and also serves as a general buffer RAM for peripherals.

---
 rtl/ram_dp_pipe.sv | 152 +++++++++++++++
 tb/tb_ram_dp_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_pipe.sv
// ram_dp_pipe: single-clock true dual-port RAM with byte-lane write enables,
// selectable read-during-write behaviour, optional output register stage,
// per-port read-valid strobes, a write-collision flag and a zero-fill engine.
module ram_dp_pipe #(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 1024,
  parameter bit    WRITE_FIRST    = 1'b0,
  parameter bit    OUT_REG        = 1'b0,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = "",
  localparam int   ADDR_W         = $clog2(DEPTH),
  localparam int   LANES          = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  output logic              busy_o,
  input  logic              a_req_i,
  input  logic [LANES-1:0]  a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_rvalid_o,
  input  logic              b_req_i,
  input  logic [LANES-1:0]  b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_rvalid_o,
  output logic              collision_o
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] clr_addr;
  logic              init_pending;

  logic              a_acc, b_acc, a_wr, b_wr, same_wr;
  logic [DATA_W-1:0] a_old, b_old, a_self, b_self, a_store;

  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_rv_q, b_rv_q;

  // init_pending keeps busy high in the cycle between reset release and CLEAR
  assign busy_o  = (state != IDLE) || init_pending;
  assign a_acc   = a_req_i && !busy_o && !rst_i;
  assign b_acc   = b_req_i && !busy_o && !rst_i;
  assign a_wr    = a_acc && (|a_we_i);
  assign b_wr    = b_acc && (|b_we_i);
  assign same_wr = a_wr && b_wr && (a_addr_i == b_addr_i);

  // Clear engine state register and address counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      init_pending <= CLEAR_ON_RESET;
      clr_addr     <= '0;
    end else begin
      state        <= state_next;
      init_pending <= 1'b0;
      if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
      else                clr_addr <= '0;
    end
  end

  // Clear engine next-state: start on command or after reset, finish at last word
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_i || init_pending) state_next = CLEAR;
      CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane merge; on a same-address double write A's lanes overlay B's merged word
  always_comb begin
    a_old  = mem[a_addr_i];
    b_old  = mem[b_addr_i];
    a_self = a_old;
    b_self = b_old;
    for (int l = 0; l < LANES; l++) begin
      if (a_we_i[l]) a_self[l*8 +: 8] = a_wdata_i[l*8 +: 8];
      if (b_we_i[l]) b_self[l*8 +: 8] = b_wdata_i[l*8 +: 8];
    end
    a_store = same_wr ? b_self : a_old;
    for (int l = 0; l < LANES; l++) begin
      if (a_we_i[l]) a_store[l*8 +: 8] = a_wdata_i[l*8 +: 8];
    end
  end

  // Array update: clear engine or port writes (ports are locked out while clearing)
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == CLEAR) mem[clr_addr] <= '0;
    if (b_wr) mem[b_addr_i] <= b_self;
    if (a_wr) mem[a_addr_i] <= a_store;
  end

  // First read stage and collision flag; rdata only moves on an accepted request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_rv_q      <= 1'b0;
      b_rv_q      <= 1'b0;
      collision_o <= 1'b0;
    end else begin
      a_rv_q      <= a_acc;
      b_rv_q      <= b_acc;
      collision_o <= same_wr;
      if (a_acc) a_rdata_q <= WRITE_FIRST ? a_self : a_old;
      if (b_acc) b_rdata_q <= WRITE_FIRST ? b_self : b_old;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_W-1:0] a_rdata_q2, b_rdata_q2;
      logic              a_rv_q2, b_rv_q2;

      // Second read stage; holds data while nothing valid arrives from stage one
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_rdata_q2 <= '0;
          b_rdata_q2 <= '0;
          a_rv_q2    <= 1'b0;
          b_rv_q2    <= 1'b0;
        end else begin
          a_rv_q2 <= a_rv_q;
          b_rv_q2 <= b_rv_q;
          if (a_rv_q) a_rdata_q2 <= a_rdata_q;
          if (b_rv_q) b_rdata_q2 <= b_rdata_q;
        end
      end

      assign a_rdata_o  = a_rdata_q2;
      assign b_rdata_o  = b_rdata_q2;
      assign a_rvalid_o = a_rv_q2;
      assign b_rvalid_o = b_rv_q2;
    end else begin : g_out_direct
      assign a_rdata_o  = a_rdata_q;
      assign b_rdata_o  = b_rdata_q;
      assign a_rvalid_o = a_rv_q;
      assign b_rvalid_o = b_rv_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_pipe.sv
// tb_ram_dp_pipe: two ram_dp_pipe instances share one stimulus stream.
// dut0: read-first, no output register. dut1: write-first, output register.
module tb_ram_dp_pipe;

  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear;
  logic          a_req, b_req;
  logic [3:0]    a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;

  logic        busy0, a_rvalid0, b_rvalid0, coll0;
  logic [31:0] a_rdata0, b_rdata0;
  logic        busy1, a_rvalid1, b_rvalid1, coll1;
  logic [31:0] a_rdata1, b_rdata1;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_a0, cap_b0, cap_a1, cap_b1;
  logic        cap_av0, cap_bv0, cap_av1, cap_bv1;
  logic        cap_av1_early, cap_av0_late, cap_col, cap_col1, cap_col_late;

  int busy_cycles;
  int rv_count;

  ram_dp_pipe #(.DATA_W(32), .DEPTH(16), .WRITE_FIRST(1'b0), .OUT_REG(1'b0),
                .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy0),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rdata0), .a_rvalid_o(a_rvalid0),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata0), .b_rvalid_o(b_rvalid0),
    .collision_o(coll0)
  );

  ram_dp_pipe #(.DATA_W(32), .DEPTH(16), .WRITE_FIRST(1'b1), .OUT_REG(1'b1),
                .CLEAR_ON_RESET(1'b1), .INIT_FILE("")) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy1),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rdata1), .a_rvalid_o(a_rvalid1),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata1), .b_rvalid_o(b_rvalid1),
    .collision_o(coll1)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    a_req = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
  endtask

  // One-cycle request on both ports, then capture both instances' responses
  task automatic applyStimulus(input logic ar, input logic [3:0] awe,
                               input logic [AW-1:0] aad, input logic [31:0] awd,
                               input logic br, input logic [3:0] bwe,
                               input logic [AW-1:0] bad, input logic [31:0] bwd);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;
    tick();
    idleInputs();
    cap_a0 = a_rdata0; cap_b0 = b_rdata0; cap_av0 = a_rvalid0; cap_bv0 = b_rvalid0;
    cap_col = coll0; cap_col1 = coll1; cap_av1_early = a_rvalid1;
    tick();
    cap_a1 = a_rdata1; cap_b1 = b_rdata1; cap_av1 = a_rvalid1; cap_bv1 = b_rvalid1;
    cap_av0_late = a_rvalid0; cap_col_late = coll0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    idleInputs();
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy0), 32'd1);
    checkOutput("rst_busy1", 32'(busy1), 32'd1);
    checkOutput("rst_rvalid", 32'({a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1}), 32'h0);
    checkOutput("rst_rdata0", a_rdata0, 32'h0);
    checkOutput("rst_rdata1", b_rdata1, 32'h0);
    checkOutput("rst_coll", 32'({coll0, coll1}), 32'h0);

    rst = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!busy0) break;
      busy_cycles++;
    end
    checkOutput("clear_len", 32'(busy_cycles), 32'd17);

    $display("[TB] read after clear");
    applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    checkOutput("rd5_valid0", 32'(cap_av0), 32'd1);
    checkOutput("rd5_data0", cap_a0, 32'h0);
    checkOutput("rd5_b_quiet", 32'(cap_bv0), 32'd0);
    checkOutput("rd5_pulse0", 32'(cap_av0_late), 32'd0);
    checkOutput("rd5_early1", 32'(cap_av1_early), 32'd0);
    checkOutput("rd5_valid1", 32'(cap_av1), 32'd1);
    checkOutput("rd5_data1", cap_a1, 32'h0);
    checkOutput("rd5_coll", 32'(cap_col), 32'd0);

    $display("[TB] byte-lane write and read-during-write");
    applyStimulus(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0);
    checkOutput("wr3_valid0", 32'(cap_av0), 32'd1);
    checkOutput("wr3_old0", cap_a0, 32'h0);
    checkOutput("wr3_new1", cap_a1, 32'h11223344);
    applyStimulus(1'b1, 4'b0101, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0);
    checkOutput("lane_old0", cap_a0, 32'h11223344);
    checkOutput("lane_merged1", cap_a1, 32'h11AD33EF);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    checkOutput("lane_rd0", cap_b0, 32'h11AD33EF);
    checkOutput("lane_rd1", cap_b1, 32'h11AD33EF);

    $display("[TB] same-address double write");
    applyStimulus(1'b1, 4'hF, 4'd7, 32'h12345678, 1'b0, 4'h0, 4'd0, 32'h0);
    checkOutput("pre7_coll", 32'(cap_col), 32'd0);
    applyStimulus(1'b1, 4'b1100, 4'd7, 32'hAAAAAAAA, 1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB);
    checkOutput("coll_pulse0", 32'(cap_col), 32'd1);
    checkOutput("coll_pulse1", 32'(cap_col1), 32'd1);
    checkOutput("coll_drop", 32'(cap_col_late), 32'd0);
    checkOutput("coll_bvalid", 32'(cap_bv0), 32'd1);
    applyStimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    checkOutput("coll_data0", cap_a0, 32'hAAAABB78);
    checkOutput("coll_data1", cap_a1, 32'hAAAABB78);

    $display("[TB] double write to different addresses");
    applyStimulus(1'b1, 4'hF, 4'd8, 32'h88880008, 1'b1, 4'hF, 4'd9, 32'h99990009);
    checkOutput("diff_coll", 32'(cap_col), 32'd0);
    applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd8, 32'h0);
    checkOutput("diff_a0", cap_a0, 32'h99990009);
    checkOutput("diff_b0", cap_b0, 32'h88880008);
    checkOutput("diff_a1", cap_a1, 32'h99990009);
    checkOutput("diff_b1", cap_b1, 32'h88880008);

    $display("[TB] cross-port read of a word being written");
    applyStimulus(1'b1, 4'hF, 4'd2, 32'h55667788, 1'b1, 4'h0, 4'd2, 32'h0);
    checkOutput("xport_old0", cap_b0, 32'h0);
    checkOutput("xport_old1", cap_b1, 32'h0);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd2, 32'h0);
    checkOutput("xport_new0", cap_b0, 32'h55667788);
    checkOutput("xport_new1", cap_b1, 32'h55667788);

    $display("[TB] back-to-back streaming");
    for (int i = 0; i < 8; i++) begin
      a_req = 1'b1; a_we = 4'hF; a_addr = AW'(i); a_wdata = pat(i);
      tick();
    end
    idleInputs();
    tick();
    tick();
    for (int t = 0; t < 9; t++) begin
      if (t < 8) begin
        a_req = 1'b1; a_we = 4'h0; a_addr = AW'(t);
        b_req = 1'b1; b_we = 4'h0; b_addr = AW'(7 - t);
      end else begin
        idleInputs();
      end
      tick();
      if (t < 8) begin
        checkOutput("strm_v0", 32'({a_rvalid0, b_rvalid0}), 32'h3);
        checkOutput("strm_a0", a_rdata0, pat(t));
        checkOutput("strm_b0", b_rdata0, pat(7 - t));
      end else begin
        checkOutput("strm_end0", 32'({a_rvalid0, b_rvalid0}), 32'h0);
      end
      if (t >= 1) begin
        checkOutput("strm_v1", 32'({a_rvalid1, b_rvalid1}), 32'h3);
        checkOutput("strm_a1", a_rdata1, pat(t - 1));
        checkOutput("strm_b1", b_rdata1, pat(8 - t));
      end else begin
        checkOutput("strm_lat1", 32'({a_rvalid1, b_rvalid1}), 32'h0);
      end
    end
    tick();
    checkOutput("strm_end1", 32'({a_rvalid1, b_rvalid1}), 32'h0);
    checkOutput("strm_hold1", a_rdata1, pat(7));

    $display("[TB] clear command, reset mid-clear");
    clear = 1'b1;
    a_req = 1'b1; a_we = 4'h0; a_addr = 4'd4;
    tick();
    clear = 1'b0;
    a_addr = 4'd5;
    checkOutput("clr_req_valid0", 32'(a_rvalid0), 32'd1);
    checkOutput("clr_req_data0", a_rdata0, pat(4));
    checkOutput("clr_busy", 32'(busy0), 32'd1);
    tick();
    checkOutput("clr_inflight_v1", 32'(a_rvalid1), 32'd1);
    checkOutput("clr_inflight_d1", a_rdata1, pat(4));
    checkOutput("clr_ignored0", 32'(a_rvalid0), 32'd0);
    rv_count = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (a_rvalid0 || a_rvalid1) rv_count++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (a_rvalid0 || a_rvalid1 || b_rvalid0 || b_rvalid1) rv_count++;
      if (!busy0) break;
      busy_cycles++;
    end
    idleInputs();
    checkOutput("reclear_len", 32'(busy_cycles), 32'd17);
    checkOutput("busy_no_rvalid", 32'(rv_count), 32'd0);

    for (int t = 0; t < 17; t++) begin
      if (t < 16) begin
        a_req = 1'b1; a_we = 4'h0; a_addr = AW'(t);
        b_req = 1'b1; b_we = 4'h0; b_addr = AW'(15 - t);
      end else begin
        idleInputs();
      end
      tick();
      if (t < 16) begin
        checkOutput("zero_v0", 32'({a_rvalid0, b_rvalid0}), 32'h3);
        checkOutput("zero_a0", a_rdata0, 32'h0);
        checkOutput("zero_b0", b_rdata0, 32'h0);
      end
      if (t >= 1) begin
        checkOutput("zero_a1", a_rdata1, 32'h0);
        checkOutput("zero_b1", b_rdata1, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
